// File: rtl/udp_audio_depack.sv
// UDP audio payload depacketiser: validates the header, stages samples speculatively
// into a jitter buffer, commits whole packets only, and plays them out with prefill/underrun recovery.
module udp_audio_depack #(
  parameter int          FIFO_AW = 10,
  parameter int          PREFILL = 256,
  parameter logic [15:0] MAGIC   = 16'hA55A
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_last,
  input  logic               sample_req,
  output logic [15:0]        sample_out,
  output logic               playing,
  output logic [FIFO_AW:0]   fill_level,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_drop_cnt,
  output logic [15:0]        seq_gap_cnt,
  output logic [15:0]        underrun_cnt
);

  localparam int              PW        = FIFO_AW + 1;
  localparam logic [PW-1:0]   DEPTH     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [31:0]     PREFILL_W = 32'(PREFILL);

  typedef enum logic [2:0] {
    P_HDR0, P_HDR1, P_SEQ, P_CNT, P_PAY_HI, P_PAY_LO, P_DROP
  } pstate_t;

  typedef enum logic {B_PRIME, B_PLAY} bstate_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pstate_t       r_pst, w_pst_nxt;
  bstate_t       r_bst, w_bst_nxt;

  logic [PW-1:0] r_wr_spec, r_wr_commit, r_rd, r_fill;
  logic [PW-1:0] w_wr_commit_nxt, w_rd_nxt, w_free;
  logic [7:0]    r_hi, r_seq, r_last_seq, r_n, r_idx;
  logic          r_have_seq;
  logic [15:0]   r_sample;
  logic [15:0]   r_ok_cnt, r_drop_cnt, r_gap_cnt, r_under_cnt;
  logic [15:0]   r_mem [0:(1<<FIFO_AW)-1];

  logic          w_n_bad, w_nth, w_wr, w_commit, w_drop, w_pop, w_under, w_gap;

  // Free space is judged against committed data only; reads can only grow it.
  assign w_free   = DEPTH - (r_wr_commit - r_rd);
  assign w_n_bad  = (rx_data == 8'd0) || (32'(rx_data) > 32'(w_free));
  assign w_nth    = (r_idx == r_n - 8'd1);
  assign w_wr     = rx_valid && (r_pst == P_PAY_LO);
  assign w_commit = w_wr && w_nth && rx_last;
  assign w_drop   = rx_valid && rx_last && !w_commit;
  assign w_pop    = (r_bst == B_PLAY) && sample_req && (r_fill != '0);
  assign w_under  = (r_bst == B_PLAY) && sample_req && (r_fill == '0);
  assign w_gap    = r_have_seq && (r_seq != r_last_seq + 8'd1);

  assign w_wr_commit_nxt = w_commit ? r_wr_spec + 1'b1 : r_wr_commit;
  assign w_rd_nxt        = w_pop ? r_rd + 1'b1 : r_rd;

  always_comb begin
    w_pst_nxt = r_pst;
    if (rx_valid) begin
      if (rx_last) begin
        w_pst_nxt = P_HDR0;
      end else begin
        case (r_pst)
          P_HDR0:   w_pst_nxt = (rx_data == MAGIC[15:8]) ? P_HDR1 : P_DROP;
          P_HDR1:   w_pst_nxt = (rx_data == MAGIC[7:0])  ? P_SEQ  : P_DROP;
          P_SEQ:    w_pst_nxt = P_CNT;
          P_CNT:    w_pst_nxt = w_n_bad ? P_DROP : P_PAY_HI;
          P_PAY_HI: w_pst_nxt = P_PAY_LO;
          P_PAY_LO: w_pst_nxt = w_nth ? P_DROP : P_PAY_HI;
          P_DROP:   w_pst_nxt = P_DROP;
          default:  w_pst_nxt = P_HDR0;
        endcase
      end
    end
  end

  always_comb begin
    w_bst_nxt = r_bst;
    case (r_bst)
      B_PRIME: if (32'(r_fill) >= PREFILL_W) w_bst_nxt = B_PLAY;
      B_PLAY:  if (w_under) w_bst_nxt = B_PRIME;
      default: w_bst_nxt = B_PRIME;
    endcase
  end

  // Control: state, pointers, counters
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pst       <= P_HDR0;
      r_bst       <= B_PRIME;
      r_wr_spec   <= '0;
      r_wr_commit <= '0;
      r_rd        <= '0;
      r_fill      <= '0;
      r_have_seq  <= 1'b0;
      r_sample    <= '0;
      r_ok_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_under_cnt <= '0;
    end else begin
      r_pst       <= w_pst_nxt;
      r_bst       <= w_bst_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      r_rd        <= w_rd_nxt;
      r_fill      <= w_wr_commit_nxt - w_rd_nxt;
      if (w_drop) begin
        r_wr_spec  <= r_wr_commit;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end else if (w_wr) begin
        r_wr_spec <= r_wr_spec + 1'b1;
      end
      if (w_commit) begin
        r_ok_cnt   <= sat_inc(r_ok_cnt);
        r_have_seq <= 1'b1;
        if (w_gap) r_gap_cnt <= sat_inc(r_gap_cnt);
      end
      if (w_pop) begin
        r_sample <= r_mem[r_rd[FIFO_AW-1:0]];
      end else if (w_under) begin
        r_sample    <= '0;
        r_under_cnt <= sat_inc(r_under_cnt);
      end
    end
  end

  // Data: header fields, payload staging and sample RAM
  always_ff @(posedge sys_clk) begin
    if (rx_valid && (r_pst == P_SEQ)) r_seq <= rx_data;
    if (rx_valid && (r_pst == P_CNT)) begin
      r_n   <= rx_data;
      r_idx <= 8'd0;
    end
    if (rx_valid && (r_pst == P_PAY_HI)) r_hi <= rx_data;
    if (w_wr) begin
      r_mem[r_wr_spec[FIFO_AW-1:0]] <= {r_hi, rx_data};
      r_idx <= r_idx + 8'd1;
    end
    if (w_commit) r_last_seq <= r_seq;
  end

  assign sample_out   = r_sample;
  assign playing      = (r_bst == B_PLAY);
  assign fill_level   = r_fill;
  assign pkt_ok_cnt   = r_ok_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
  assign seq_gap_cnt  = r_gap_cnt;
  assign underrun_cnt = r_under_cnt;

endmodule

// File: tb/tb_udp_audio_depack.sv
// Scoreboard bench for udp_audio_depack: stimulus queues expected samples/status,
// a negedge monitor pops and compares against the DUT outputs.
module tb_udp_audio_depack;

  localparam int AW = 4;
  localparam int PF = 4;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_last = 1'b0;
  logic          sample_req = 1'b0;
  logic [15:0]   sample_out;
  logic          playing;
  logic [AW:0]   fill_level;
  logic [15:0]   pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, underrun_cnt;

  always #5 sys_clk = ~sys_clk;

  udp_audio_depack #(.FIFO_AW(AW), .PREFILL(PF), .MAGIC(16'hA55A)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_last(rx_last), .sample_req(sample_req), .sample_out(sample_out),
    .playing(playing), .fill_level(fill_level), .pkt_ok_cnt(pkt_ok_cnt),
    .pkt_drop_cnt(pkt_drop_cnt), .seq_gap_cnt(seq_gap_cnt), .underrun_cnt(underrun_cnt)
  );

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } stat_t;

  localparam int S_FILL = 0, S_OK = 1, S_DROP = 2, S_GAP = 3, S_UNDER = 4,
                 S_PLAY = 5, S_SOUT = 6, S_PEND = 7;

  stat_t       stat_q[$];
  logic [15:0] samp_q[$];
  logic [15:0] pay[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        req_d = 1'b0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_FILL:  return 32'(fill_level);
      S_OK:    return 32'(pkt_ok_cnt);
      S_DROP:  return 32'(pkt_drop_cnt);
      S_GAP:   return 32'(seq_gap_cnt);
      S_UNDER: return 32'(underrun_cnt);
      S_PLAY:  return 32'(playing);
      S_SOUT:  return 32'(sample_out);
      S_PEND:  return 32'(samp_q.size());
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge sys_clk) req_d <= sample_req;

  always @(negedge sys_clk) begin
    logic [15:0] e;
    logic [31:0] a;
    stat_t       s;
    if (req_d) begin
      n_cmp++;
      if (samp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sample_out: got %h on a request with no expected value queued", sample_out);
      end else begin
        e = samp_q.pop_front();
        if (sample_out !== e) begin
          n_bad++;
          $display("FAIL sample_out: got %h, required %h", sample_out, e);
        end
      end
    end
    while (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      a = actual(s.sel);
      n_cmp++;
      if (a !== 32'(s.exp)) begin
        n_bad++;
        $display("FAIL %s: got %0h, required %0h", s.name, a, s.exp);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input int exp);
    stat_t s;
    s.name = name;
    s.sel  = sel;
    s.exp  = exp;
    stat_q.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_last  = last;
    tick();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  // Sends A5 5A seq N and the samples in pay; optionally requests a sample on the last byte.
  task automatic send_pkt(input logic [7:0] seq, input bit req_last, input logic [15:0] req_exp);
    int n;
    n = pay.size();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(seq, 1'b0);
    send_byte(8'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i][15:8], 1'b0);
      if (i == n - 1 && req_last) begin
        samp_q.push_back(req_exp);
        sample_req = 1'b1;
      end
      send_byte(pay[i][7:0], i == n - 1);
      sample_req = 1'b0;
    end
  endtask

  task automatic request(input logic [15:0] exp);
    samp_q.push_back(exp);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset fill", S_FILL, 0);
    chk("reset ok", S_OK, 0);
    chk("reset drop", S_DROP, 0);
    chk("reset playing", S_PLAY, 0);
    chk("reset sample_out", S_SOUT, 0);

    // Basic packet, playout and underrun
    pay = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    send_pkt(8'd0, 1'b0, 16'h0);
    tick();
    chk("t1 fill", S_FILL, 4);
    chk("t1 ok", S_OK, 1);
    chk("t1 playing", S_PLAY, 1);
    request(16'h1234);
    request(16'h5678);
    request(16'h9ABC);
    request(16'hDEF0);
    request(16'h0000);
    chk("t1 underrun", S_UNDER, 1);
    chk("t1 playing after underrun", S_PLAY, 0);
    chk("t1 fill empty", S_FILL, 0);

    // Bad magic, rx_last on byte 10
    for (int i = 0; i < 10; i++)
      send_byte((i == 0) ? 8'hA5 : (i == 1) ? 8'h5B : 8'(i), i == 9);
    chk("t2 drop", S_DROP, 1);
    chk("t2 fill", S_FILL, 0);
    pay = '{16'h1111, 16'h2222};
    send_pkt(8'd1, 1'b0, 16'h0);
    chk("t2 ok", S_OK, 2);
    chk("t2 fill after good", S_FILL, 2);
    chk("t2 gap", S_GAP, 0);

    // Short datagram (N=3, ends on 4th payload byte) then a good packet overwrites it
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'd2, 1'b0);
    send_byte(8'd3, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    chk("t3 drop", S_DROP, 2);
    chk("t3 fill after drop", S_FILL, 2);
    pay = '{16'hAAAA, 16'hBBBB};
    send_pkt(8'd2, 1'b0, 16'h0);
    tick();
    chk("t3 fill", S_FILL, 4);
    chk("t3 ok", S_OK, 3);
    chk("t3 playing", S_PLAY, 1);
    request(16'h1111);
    request(16'h2222);
    request(16'hAAAA);
    request(16'hBBBB);
    chk("t3 fill drained", S_FILL, 0);
    chk("t3 still playing", S_PLAY, 1);

    // Sequence gap: 2 -> 4 -> 5
    pay = '{16'h0004};
    send_pkt(8'd4, 1'b0, 16'h0);
    pay = '{16'h0005};
    send_pkt(8'd5, 1'b0, 16'h0);
    chk("t4 gap", S_GAP, 1);
    chk("t4 ok", S_OK, 5);
    chk("t4 fill", S_FILL, 2);
    request(16'h0004);
    request(16'h0005);

    // Free-space limit on a 16-deep buffer, then commit coinciding with pop
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(16'h0100 + 16'(i));
    send_pkt(8'd6, 1'b0, 16'h0);
    chk("t5 fill 12", S_FILL, 12);
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(16'h0700 + 16'(i));
    send_pkt(8'd7, 1'b0, 16'h0);
    chk("t5 drop oversize", S_DROP, 3);
    chk("t5 fill unchanged", S_FILL, 12);
    chk("t5 ok before fit", S_OK, 6);
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(16'h0710 + 16'(i));
    send_pkt(8'd7, 1'b0, 16'h0);
    chk("t5 fill full", S_FILL, 16);
    chk("t5 ok fit", S_OK, 7);
    request(16'h0100);
    chk("t5 fill after pop", S_FILL, 15);
    pay = '{16'h0800};
    send_pkt(8'd8, 1'b1, 16'h0101);
    chk("t5 fill commit+pop", S_FILL, 15);
    chk("t5 ok", S_OK, 8);
    chk("t5 gap", S_GAP, 1);

    // Reset mid-payload
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'd9, 1'b0);
    send_byte(8'd2, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 fill", S_FILL, 0);
    chk("t6 ok", S_OK, 0);
    chk("t6 drop", S_DROP, 0);
    chk("t6 gap", S_GAP, 0);
    chk("t6 underrun", S_UNDER, 0);
    chk("t6 playing", S_PLAY, 0);
    chk("t6 sample_out", S_SOUT, 0);
    pay = '{16'h7777};
    send_pkt(8'd0, 1'b0, 16'h0);
    chk("t6 ok after", S_OK, 1);
    chk("t6 drop after", S_DROP, 0);
    chk("t6 fill after", S_FILL, 1);
    request(16'h0000);
    chk("t6 prime ignores req", S_FILL, 1);

    tick();
    chk("pending samples", S_PEND, 0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
